// File: rtl/dht11_emulator.sv
// DHT11 sensor emulator: waits for a host start pulse on the open-drain data
// line, then answers with acknowledge and a 40-bit frame built from latched
// humidity/temperature values (checksum optionally corrupted).
module dht11_emulator #(
  parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] humidity,
  input  logic [7:0] temperature,
  input  logic       corrupt_cksum,
  input  logic       data_in,
  output logic       data_oe,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
  localparam logic [15:0]   START_LAST  = 16'(START_MIN_US - 1);
  localparam logic [15:0]   RESP_LAST   = 16'(RESP_DELAY_US - 1);
  localparam logic [15:0]   ACK_LAST    = 16'd79;
  localparam logic [15:0]   LOW50_LAST  = 16'd49;
  localparam logic [15:0]   ZERO_LAST   = 16'd25;
  localparam logic [15:0]   ONE_LAST    = 16'd69;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_HOST_LOW   = 3'd1;
  localparam logic [2:0] S_RESP_DELAY = 3'd2;
  localparam logic [2:0] S_ACK_LOW    = 3'd3;
  localparam logic [2:0] S_ACK_HIGH   = 3'd4;
  localparam logic [2:0] S_BIT_LOW    = 3'd5;
  localparam logic [2:0] S_BIT_HIGH   = 3'd6;
  localparam logic [2:0] S_END_LOW    = 3'd7;

  logic [2:0]    state_q, state_d;
  logic          syncMeta_q, syncLine_q;
  logic          oeHist1_q, oeHist2_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   us_q;
  logic [39:0]   frame_q;
  logic [5:0]    bitIdx_q;
  logic          data_oe_q, busy_q, frame_done_q;

  logic          tick, lineLowRaw, lineLow, hostLongEnough;
  logic [15:0]   bitHighLast;
  logic [7:0]    cksum;
  logic          latchEn, shiftEn, finish;

  assign tick       = (presc_q == PRESC_LAST);
  assign lineLowRaw = ~syncLine_q;
  // Right after we stop pulling low, the synchronizer still holds our own
  // low for two samples; those must not be mistaken for a foreign low.
  assign lineLow    = lineLowRaw & ~(oeHist1_q | oeHist2_q);
  // The IDLE sample that detected the fall is itself one low clock, so a
  // pulse of exactly START_MIN_US completes when the last prescaler slot of
  // the final microsecond is reached.
  assign hostLongEnough = (us_q > START_LAST) || ((us_q == START_LAST) && tick);
  assign bitHighLast    = frame_q[39] ? ONE_LAST : ZERO_LAST;
  assign cksum          = (humidity + temperature) ^ {7'd0, corrupt_cksum};

  assign data_oe    = data_oe_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // Two-flop synchronizer for the shared line, idle level high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta_q <= 1'b1;
      syncLine_q <= 1'b1;
    end else begin
      syncMeta_q <= data_in;
      syncLine_q <= syncMeta_q;
    end
  end

  // Next-state logic: protocol phases, host start measurement and aborts.
  always_comb begin
    state_d = state_q;
    latchEn = 1'b0;
    shiftEn = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lineLow) state_d = S_HOST_LOW;
      end
      S_HOST_LOW: begin
        if (!lineLowRaw) begin
          if (hostLongEnough) begin
            state_d = S_RESP_DELAY;
            latchEn = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RESP_DELAY: begin
        if (lineLow) state_d = S_HOST_LOW;
        else if (tick && (us_q == RESP_LAST)) state_d = S_ACK_LOW;
      end
      S_ACK_LOW: begin
        if (tick && (us_q == ACK_LAST)) state_d = S_ACK_HIGH;
      end
      S_ACK_HIGH: begin
        if (lineLow) state_d = S_HOST_LOW;
        else if (tick && (us_q == ACK_LAST)) state_d = S_BIT_LOW;
      end
      S_BIT_LOW: begin
        if (tick && (us_q == LOW50_LAST)) state_d = S_BIT_HIGH;
      end
      S_BIT_HIGH: begin
        if (lineLow) begin
          state_d = S_HOST_LOW;
        end else if (tick && (us_q == bitHighLast)) begin
          shiftEn = 1'b1;
          state_d = (bitIdx_q == 6'd39) ? S_END_LOW : S_BIT_LOW;
        end
      end
      S_END_LOW: begin
        if (tick && (us_q == LOW50_LAST)) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Microsecond prescaler and counter, both restarted on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      us_q    <= '0;
    end else if (state_d != state_q) begin
      presc_q <= '0;
      us_q    <= '0;
    end else if (tick) begin
      presc_q <= '0;
      if (us_q != 16'hFFFF) us_q <= us_q + 16'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Frame shift register: loaded when a start is accepted, shifted per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q  <= '0;
      bitIdx_q <= '0;
    end else if (latchEn) begin
      frame_q  <= {humidity, 8'h00, temperature, 8'h00, cksum};
      bitIdx_q <= '0;
    end else if (shiftEn) begin
      frame_q  <= {frame_q[38:0], 1'b0};
      bitIdx_q <= bitIdx_q + 6'd1;
    end
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      data_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      oeHist1_q    <= 1'b0;
      oeHist2_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_oe_q    <= (state_d == S_ACK_LOW) || (state_d == S_BIT_LOW) ||
                      (state_d == S_END_LOW);
      busy_q       <= ((state_d != S_IDLE) && (state_d != S_HOST_LOW)) || finish;
      frame_done_q <= finish;
      oeHist1_q    <= data_oe_q;
      oeHist2_q    <= oeHist1_q;
    end
  end

endmodule

// File: tb/tb_dht11_emulator.sv
// Scoreboard bench for dht11_emulator: the host side queues the frame it
// expects, a monitor decodes the emulator's line drive and compares.
module tb_dht11_emulator;

  localparam int unsigned CLK_HZ   = 1_000_000;
  localparam int unsigned START_US = 100;
  localparam int unsigned RESP_US  = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] humidity = 8'h00;
  logic [7:0] temperature = 8'h00;
  logic       corrupt_cksum = 1'b0;
  logic       hostLow = 1'b0;
  logic       data_in, data_oe, busy, frame_done;

  assign data_in = !(hostLow || data_oe);

  always #5 clk = ~clk;

  dht11_emulator #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .START_MIN_US (START_US),
    .RESP_DELAY_US(RESP_US)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .humidity     (humidity),
    .temperature  (temperature),
    .corrupt_cksum(corrupt_cksum),
    .data_in      (data_in),
    .data_oe      (data_oe),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  int          checks = 0;
  int          passes = 0;
  int          frameDoneCount = 0;
  int          framesExpected = 0;
  logic [39:0] expQ[$];
  int          runLens[$];
  logic        runLvls[$];
  int          runLen = 0;
  logic        curLevel = 1'b0;

  // Equality comparison with pass/fail bookkeeping.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  // Duration comparison allowing a small clock tolerance.
  task automatic checkNear(input string name, input int actual, input int expected, input int tol);
    checks++;
    if ((actual >= expected - tol) && (actual <= expected + tol)) passes++;
    else $display("[TB] FAIL %s: actual %0d, required %0d +/- %0d", name, actual, expected, tol);
  endtask

  // Reference frame: humidity, 0, temperature, 0, checksum.
  function automatic logic [39:0] modelFrame(input logic [7:0] h, input logic [7:0] t, input logic c);
    int sum;
    sum = (int'(h) + int'(t)) % 256;
    if (c) sum = sum ^ 1;
    return {h, 8'h00, t, 8'h00, 8'(sum)};
  endfunction

  // Decode the collected runs of one completed frame and compare.
  task automatic evaluateFrame();
    logic [39:0] expFrame, got;
    int badLow, badHigh, badLvl, hi;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_frame", 1, 0);
      return;
    end
    expFrame = expQ.pop_front();
    checkOutput("run_count", runLens.size(), 84);
    if (runLens.size() != 84) return;
    badLow = 0; badHigh = 0; badLvl = 0; got = '0;
    for (int i = 0; i < 84; i++) if (runLvls[i] != logic'(i % 2)) badLvl++;
    checkNear("resp_delay", runLens[0], RESP_US, 1);
    checkNear("ack_low", runLens[1], 80, 1);
    checkNear("ack_high", runLens[2], 80, 1);
    for (int i = 0; i < 40; i++) begin
      hi = runLens[4 + 2 * i];
      if ((runLens[3 + 2 * i] < 49) || (runLens[3 + 2 * i] > 51)) badLow++;
      if (!(((hi >= 25) && (hi <= 27)) || ((hi >= 69) && (hi <= 71)))) badHigh++;
      got[39 - i] = (hi > 48);
    end
    checkNear("end_low", runLens[83], 50, 1);
    checkOutput("levels", badLvl, 0);
    checkOutput("bit_low_errs", badLow, 0);
    checkOutput("bit_high_errs", badHigh, 0);
    for (int b = 0; b < 5; b++)
      checkOutput($sformatf("byte%0d", b), got[39 - 8 * b -: 8], expFrame[39 - 8 * b -: 8]);
  endtask

  // Monitor: collect line-drive runs while busy, judge on frame_done.
  always @(negedge clk) begin
    if (frame_done) frameDoneCount++;
    if (busy && !frame_done) begin
      if ((runLen > 0) && (data_oe == curLevel)) runLen++;
      else begin
        if (runLen > 0) begin
          runLens.push_back(runLen);
          runLvls.push_back(curLevel);
        end
        curLevel = data_oe;
        runLen = 1;
      end
    end else begin
      if (busy && frame_done) begin
        if (runLen > 0) begin
          runLens.push_back(runLen);
          runLvls.push_back(curLevel);
        end
        evaluateFrame();
      end
      runLens.delete();
      runLvls.delete();
      runLen = 0;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hostPulse(input int cycles);
    @(negedge clk);
    hostLow = 1'b1;
    waitCycles(cycles);
    hostLow = 1'b0;
  endtask

  // Program the sensor values and issue a host start of lowLen microseconds.
  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] t, input logic c,
                               input int lowLen, input bit accept);
    humidity = h;
    temperature = t;
    corrupt_cksum = c;
    if (accept) begin
      expQ.push_back(modelFrame(h, t, c));
      framesExpected++;
    end
    hostPulse(lowLen);
  endtask

  task automatic waitFrameEnd(input int startCount, input string name);
    int n = 0;
    while ((frameDoneCount == startCount) && (n < 7000)) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_done"}, frameDoneCount - startCount, 1);
    waitCycles(10);
  endtask

  task automatic waitOeRises(input int count, input int budget, input string name);
    logic prev;
    int rises = 0;
    int n = 0;
    prev = data_oe;
    while ((rises < count) && (n < budget)) begin
      @(negedge clk);
      n++;
      if (data_oe && !prev) rises++;
      prev = data_oe;
    end
    checkOutput(name, rises, count);
  endtask

  task automatic waitOeLow(input int budget, input string name);
    int n = 0;
    while ((data_oe !== 1'b0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, data_oe, 0);
  endtask

  // Count cycles of any drive or busy over a quiet window.
  task automatic quietWindow(input int cycles, input string name);
    int oeCnt = 0;
    int busyCnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (data_oe) oeCnt++;
      if (busy) busyCnt++;
    end
    checkOutput({name, "_oe_cycles"}, oeCnt, 0);
    checkOutput({name, "_busy_cycles"}, busyCnt, 0);
  endtask

  initial begin
    int fd;
    waitCycles(3);
    checkOutput("reset_data_oe", data_oe, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    rst_n = 1'b1;
    waitCycles(5);

    $display("[TB] basic frame");
    fd = frameDoneCount;
    applyStimulus(8'h0A, 8'h21, 1'b0, START_US, 1'b1);
    waitFrameEnd(fd, "basic");

    $display("[TB] short start pulse");
    fd = frameDoneCount;
    applyStimulus(8'h33, 8'h44, 1'b0, START_US - 1, 1'b0);
    quietWindow(300, "short");
    checkOutput("short_no_done", frameDoneCount - fd, 0);
    fd = frameDoneCount;
    applyStimulus(8'($urandom), 8'($urandom), 1'b0, START_US, 1'b1);
    waitFrameEnd(fd, "after_short");

    $display("[TB] checksum wrap and corruption");
    fd = frameDoneCount;
    applyStimulus(8'hC8, 8'h64, 1'b0, START_US, 1'b1);
    waitFrameEnd(fd, "cksum_wrap");
    fd = frameDoneCount;
    applyStimulus(8'hC8, 8'h64, 1'b1, START_US + 40, 1'b1);
    waitFrameEnd(fd, "cksum_corrupt");

    $display("[TB] latching");
    fd = frameDoneCount;
    applyStimulus(8'h0A, 8'h21, 1'b0, START_US, 1'b1);
    waitOeRises(12, 2000, "reach_bit10");
    temperature = 8'h05;
    waitFrameEnd(fd, "latch_first");
    fd = frameDoneCount;
    applyStimulus(8'h0A, 8'h05, 1'b0, START_US, 1'b1);
    waitFrameEnd(fd, "latch_second");

    $display("[TB] host abort");
    fd = frameDoneCount;
    applyStimulus(8'h55, 8'hAA, 1'b0, START_US, 1'b0);
    waitOeRises(1, 300, "abort_ack_low");
    waitOeLow(200, "abort_ack_high");
    waitCycles(4);
    hostPulse(30);
    quietWindow(300, "abort");
    checkOutput("abort_no_done", frameDoneCount - fd, 0);

    $display("[TB] reset mid-frame");
    fd = frameDoneCount;
    applyStimulus(8'h12, 8'h34, 1'b0, START_US, 1'b0);
    waitOeRises(6, 2000, "reach_bit4");
    #2;
    checkOutput("pre_reset_oe", data_oe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_oe", data_oe, 0);
    checkOutput("async_reset_busy", busy, 0);
    waitCycles(5);
    rst_n = 1'b1;
    waitCycles(5);
    checkOutput("reset_no_done", frameDoneCount - fd, 0);
    fd = frameDoneCount;
    applyStimulus(8'($urandom), 8'($urandom), 1'b0, START_US, 1'b1);
    waitFrameEnd(fd, "after_reset");

    $display("[TB] random frames");
    for (int k = 0; k < 3; k++) begin
      fd = frameDoneCount;
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                    START_US + int'($urandom_range(0, 50)), 1'b1);
      waitFrameEnd(fd, $sformatf("random%0d", k));
    end

    checkOutput("pending_expected", expQ.size(), 0);
    checkOutput("frame_done_total", frameDoneCount, framesExpected);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/dht11_emulator.md
# dht11_emulator

Synthesizable DHT11 sensor emulator: the responder end of the single-wire protocol whose initiator is the existing DHT11 reader. It detects the host start pulse on the open-drain data line and answers with a standard DHT11 frame built from programmable humidity and temperature values. It sits on the board-level test harness next to the cold-storage top, so the reader, controller, UART and LCD path run closed-loop without a physical sensor.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: clock frequency. Must be an integer multiple of 1 MHz.
- `START_MIN_US`, 18000: minimum host low time (µs) accepted as a start pulse.
- `RESP_DELAY_US`, 30: delay from host release to the acknowledge-low phase.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. One clock domain; reset is asynchronous and active-low.
- `humidity`, input, 8: integer humidity value to report.
- `temperature`, input, 8: integer temperature value to report.
- `corrupt_cksum`, input, 1: when 1, the transmitted checksum has bit 0 inverted.
- `data_in`, input, 1: raw sampled level of the shared data line.
- `data_oe`, output, 1: 1 means pull the line low (open drain). 0 means release it.
- `busy`, output, 1: high from start-pulse acceptance until the end of the frame.
- `frame_done`, output, 1: one-cycle pulse when a frame completes.

## Operation
- `data_in` passes through a 2-flop synchronizer. Every "line" reference below means the synchronized value.
- A µs tick prescaler divides by `DIV = CLK_FREQ_HZ/1e6`. The prescaler and the 16-bit µs counter both clear on every state entry, so an N-µs phase lasts exactly N·DIV clocks.
- States:
  - **IDLE**
    - Outputs: `data_oe`=0, `busy`=0.
    - Line low → HOST_LOW.
  - **HOST_LOW**
    - Count µs while the line is low. The counter saturates at 0xFFFF.
    - Line high with count ≥ `START_MIN_US`: latch `humidity`, `temperature` and `corrupt_cksum`, then go to RESP_DELAY.
    - Line high with count below `START_MIN_US`: return to IDLE. This is a glitch or short pulse and is ignored.
  - **RESP_DELAY**
    - Line released for `RESP_DELAY_US`, then → ACK_LOW.
  - **ACK_LOW**
    - `data_oe`=1 for 80 µs, then → ACK_HIGH.
  - **ACK_HIGH**
    - Line released for 80 µs, then → BIT_LOW.
  - **BIT_LOW**
    - `data_oe`=1 for 50 µs, then → BIT_HIGH.
  - **BIT_HIGH**
    - Line released for 26 µs if the current bit is 0, or 70 µs if it is 1.
    - Then → BIT_LOW for the next bit, or → END_LOW after bit 39.
  - **END_LOW**
    - `data_oe`=1 for 50 µs, then release, pulse `frame_done`, and → IDLE.
- Frame: 40 bits, MSB first, byte order humidity, 0x00, temperature, 0x00, checksum.
  - Checksum = (humidity + temperature) mod 256.
  - The checksum is XORed with 0x01 if the latched `corrupt_cksum` is set.
- Latched values stay frozen for the whole frame. Input changes mid-frame affect only the next frame.
- `busy`=1 in every state from RESP_DELAY through END_LOW, including the `frame_done` cycle.
- Abort rule: in any released state (RESP_DELAY, ACK_HIGH, BIT_HIGH), if the line reads low:
  - Stop the frame with no `frame_done` pulse.
  - → HOST_LOW with the µs count cleared. The foreign low is then measured as a possible new start.
- The line is not monitored while `data_oe`=1.
- Reset mid-frame: `data_oe` releases asynchronously at once and the FSM goes to IDLE.

## Timing
- Reset values:
  - Outputs: `data_oe`=0, `busy`=0, `frame_done`=0.
  - Internal: state IDLE, counters 0, synchronizer flops 1 (line idle high).
- `data_oe` is a registered output.
- Input latency: 2 clocks of synchronizer plus 1 clock of FSM registration from a `data_in` edge to the state change.
- The host start pulse is measured from the synchronized falling edge to the synchronized rising edge. The count compares at whole-µs resolution.
- Frame duration after host release:
  - Fixed part: `RESP_DELAY_US` + 160 µs + 40·50 µs + 50 µs.
  - Plus the sum of the bit-high times: 26 µs per 0 bit, 70 µs per 1 bit.
- `frame_done` fires on the same clock that `data_oe` returns to 0 after END_LOW.
- A new start pulse is accepted immediately after return to IDLE. There is no holdoff.

## Test plan
- **Basic frame.** Set humidity=0x0A, temperature=0x21. Host drives low 18 ms, then releases.
  - Decoded bits: 0x0A, 0x00, 0x21, 0x00, 0x2B.
  - ACK low 80 µs and ACK high 80 µs, within ±1 clock.
  - One `frame_done` pulse. `busy` is high through the whole frame.
- **Short start pulse.** Host low for 17.9 ms, then released.
  - `data_oe` stays 0 and `busy` stays 0.
  - A following 18 ms pulse produces a normal frame.
- **Checksum wrap and corruption.**
  - humidity=0xC8, temperature=0x64: checksum byte 0x2C.
  - Same values with `corrupt_cksum`=1: checksum byte 0x2D.
- **Latching.** Change temperature 0x21→0x05 during bit 10.
  - The current frame still carries 0x21 and checksum 0x2B.
  - The next frame carries 0x05.
- **Host abort.** Host pulls low 5 µs into the ACK_HIGH phase.
  - No further low drive, no `frame_done`.
  - FSM enters HOST_LOW. A 30 µs low then returns it to IDLE.
- **Reset mid-frame.** Assert `rst_n`=0 during BIT_LOW.
  - `data_oe` drops to 0 asynchronously, before the next clock edge.
  - After release, a fresh 18 ms start yields a complete, correct frame.
